leading_one_expand: RTL and testbench



---
 rtl/leading_one_expand.sv | 112 +++++++++++
 tb/tb_leading_one_expand.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leading_one_expand.sv
// Rebuilds a WIDTH-bit integer from a leading-one position code and the fraction bits below it.
// Two-stage valid/ready pipeline. Define LEADING_ONE_EXPAND_ROUND_EN for round-to-nearest (ties up).
module leading_one_expand #(
  parameter int WIDTH = 8,
  parameter int POS_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [POS_W-1:0] in_pos,
  input  logic [WIDTH-2:0] in_frac,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  localparam logic [POS_W-1:0] WIDTH_CODE = POS_W'(WIDTH);

  if (WIDTH < 2) begin : g_bad_width
    $error("leading_one_expand: WIDTH must be at least 2");
  end
  if ((2 ** POS_W) <= WIDTH) begin : g_bad_pos_w
    $error("leading_one_expand: POS_W too narrow to encode WIDTH");
  end

  function automatic logic illegal_pos(input logic [POS_W-1:0] pos);
    return pos > WIDTH_CODE;
  endfunction

`ifdef LEADING_ONE_EXPAND_ROUND_EN
  // sh is the number of dropped fraction bits; the round bit is the highest of them.
  function automatic logic [WIDTH-1:0] round_half_up(input logic [WIDTH-1:0] trunc,
                                                     input logic [WIDTH-1:0] mant,
                                                     input logic [POS_W-1:0] sh);
    logic [WIDTH-1:0] rmask;
    logic             rbit;
    if (sh == '0) return trunc;
    rmask = {{(WIDTH-1){1'b0}}, 1'b1} << (sh - POS_W'(1));
    rbit  = |(mant & rmask);
    return trunc + {{(WIDTH-1){1'b0}}, rbit};
  endfunction
`endif

  // The implicit leading one is placed on top of the fraction, then shifted down into place.
  function automatic logic [WIDTH-1:0] expand(input logic [POS_W-1:0] pos,
                                              input logic [WIDTH-2:0] frac);
    logic [WIDTH-1:0] mant;
    logic [POS_W-1:0] sh;
    logic [WIDTH-1:0] res;
    mant = {1'b1, frac};
    sh   = WIDTH_CODE - pos;
    res  = '0;
    if ((pos != '0) && !illegal_pos(pos)) begin
      res = mant >> sh;
`ifdef LEADING_ONE_EXPAND_ROUND_EN
      res = round_half_up(res, mant, sh);
`endif
    end
    return res;
  endfunction

  logic             vld_p1;
  logic [POS_W-1:0] pos_p1;
  logic [WIDTH-2:0] frac_p1;
  logic             vld_p2;
  logic [WIDTH-1:0] data_p2;
  logic             err_p2;
  logic             s1_rdy;
  logic             s2_rdy;

  assign s2_rdy   = !vld_p2 || out_ready;
  assign s1_rdy   = !vld_p1 || s2_rdy;
  assign in_ready = s1_rdy;

  // Stage 1: capture position code and fraction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (s1_rdy) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_rdy && in_valid) begin
      pos_p1  <= in_pos;
      frac_p1 <= in_frac;
    end
  end

  // Stage 2: expansion into the output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      err_p2  <= 1'b0;
    end else if (s2_rdy) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_p2 <= expand(pos_p1, frac_p1);
        err_p2  <= illegal_pos(pos_p1);
      end
    end
  end

  assign out_valid = vld_p2;
  assign out_data  = data_p2;
  assign out_err   = err_p2;

endmodule

// File: tb/tb_leading_one_expand.sv
// Self-checking bench for leading_one_expand: directed vectors, illegal codes, backpressure,
// randomized streaming against an arithmetic reference model, and reset with beats in flight.
module tb_leading_one_expand;

  localparam int W  = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_pos = '0;
  logic [W-2:0]  in_frac = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_err;

  int errors = 0;
  int checks = 0;

  leading_one_expand #(.WIDTH(W), .POS_W(PW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pos(in_pos), .in_frac(in_frac),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Reference: value = 2^(k-1) + top (k-1) fraction bits, optionally plus the next fraction bit.
  function automatic logic [W:0] model(input int k, input int frac);
    int v;
    if (k == 0) return '0;
    if (k > W) return (W+1)'(1 << W);
    v = (1 << (k - 1)) + (frac >> (W - k));
`ifdef LEADING_ONE_EXPAND_ROUND_EN
    if (k < W) v = v + ((frac >> (W - k - 1)) & 1);
`endif
    return (W+1)'(v);
  endfunction

  // One cycle: drive inputs after the falling edge, sample just after.
  task automatic step(input logic iv, input logic [PW-1:0] ip, input logic [W-2:0] ifr,
                      input logic ordy, output logic acc, output logic drn,
                      output logic [W-1:0] d, output logic e, output logic ir, output logic ov);
    @(negedge clk);
    in_valid  = iv;
    in_pos    = ip;
    in_frac   = ifr;
    out_ready = ordy;
    #1;
    ir  = in_ready;
    ov  = out_valid;
    d   = out_data;
    e   = out_err;
    acc = iv && in_ready;
    drn = out_valid && ordy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b data=%h err=%b, want 0/00/0", out_valid, out_data, out_err);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [PW-1:0] dpos [8] = '{4'd5, 4'd3, 4'd8, 4'd1, 4'd0, 4'd9, 4'd15, 4'd5};
    logic [W-2:0]  dfrac[8] = '{7'h5B, 7'h70, 7'h7F, 7'h7F, 7'h55, 7'h7F, 7'h2A, 7'h5B};
`ifdef LEADING_ONE_EXPAND_ROUND_EN
    logic [W-1:0]  ddata[8] = '{8'h1B, 8'h08, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00, 8'h1B};
`else
    logic [W-1:0]  ddata[8] = '{8'h1B, 8'h07, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h1B};
`endif
    logic          derr [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic acc, drn, e, ir, ov;
    logic [W-1:0] d;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, dpos[i], dfrac[i], 1'b1, acc, drn, d, e, ir, ov);
      checks++;
      if (acc !== 1'b1) begin
        errors++;
        $display("FAIL dir_accept[%0d]: got in_ready=%b, want 1", i, ir);
      end
      step(1'b0, '0, '0, 1'b1, acc, drn, d, e, ir, ov);
      checks++;
      if (ov !== 1'b0) begin
        errors++;
        $display("FAIL dir_early_valid[%0d]: got out_valid=%b, want 0", i, ov);
      end
      step(1'b0, '0, '0, 1'b1, acc, drn, d, e, ir, ov);
      checks++;
      if (ov !== 1'b1 || d !== ddata[i] || e !== derr[i]) begin
        errors++;
        $display("FAIL dir_result[%0d] pos=%0d frac=%h: got valid=%b data=%h err=%b, want 1/%h/%b",
                 i, dpos[i], dfrac[i], ov, d, e, ddata[i], derr[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] bpos [10];
    logic [W-2:0]  bfrac[10];
    logic [W:0]    q[$];
    logic [W:0]    exp_v;
    logic acc, drn, e, ir, ov, ordy, exp_ir, prev_stall, saw_low;
    logic [W-1:0] d, prev_d;
    logic prev_e;
    int idx, got, inflight, cyc;
    for (int i = 0; i < 10; i++) begin
      bpos[i]  = PW'($urandom_range(1, W));
      bfrac[i] = (W-1)'($urandom);
    end
    idx = 0; got = 0; inflight = 0; cyc = 0;
    prev_stall = 1'b0; prev_d = '0; prev_e = 1'b0; saw_low = 1'b0;
    while (got < 10 && cyc < 200) begin
      ordy = ((cyc % 3) == 0);
      step(idx < 10, (idx < 10) ? bpos[idx] : '0, (idx < 10) ? bfrac[idx] : '0, ordy,
           acc, drn, d, e, ir, ov);
      exp_ir = !(inflight == 2 && !ordy);
      checks++;
      if (ir !== exp_ir) begin
        errors++;
        $display("FAIL bp_in_ready cyc=%0d: got %b, want %b", cyc, ir, exp_ir);
      end
      if (!ir) saw_low = 1'b1;
      if (prev_stall) begin
        checks++;
        if (ov !== 1'b1 || d !== prev_d || e !== prev_e) begin
          errors++;
          $display("FAIL bp_hold cyc=%0d: got valid=%b data=%h err=%b, want 1/%h/%b",
                   cyc, ov, d, e, prev_d, prev_e);
        end
      end
      prev_stall = ov && !ordy;
      prev_d = d;
      prev_e = e;
      if (drn) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL bp_extra_beat: got data=%h, want none", d);
        end else begin
          exp_v = q.pop_front();
          if ({e, d} !== exp_v) begin
            errors++;
            $display("FAIL bp_data beat %0d: got err=%b data=%h, want err=%b data=%h",
                     got, e, d, exp_v[W], exp_v[W-1:0]);
          end
        end
        got++;
        inflight--;
      end
      if (acc) begin
        q.push_back(model(int'(bpos[idx]), int'(bfrac[idx])));
        idx++;
        inflight++;
      end
      cyc++;
    end
    checks++;
    if (got != 10 || q.size() != 0) begin
      errors++;
      $display("FAIL bp_count: got %0d beats (%0d pending), want 10 (0 pending)", got, q.size());
    end
    checks++;
    if (saw_low !== 1'b1) begin
      errors++;
      $display("FAIL bp_in_ready_low: got never low, want low while both stages full");
    end
  endtask

  task automatic test_random();
    logic [W:0] q[$];
    logic [W:0] exp_v;
    logic acc, drn, e, ir, ov, ordy, iv, exp_ir;
    logic [W-1:0] d;
    logic [PW-1:0] p;
    logic [W-2:0] f;
    int sent, got, inflight, cyc;
    sent = 0; got = 0; inflight = 0; cyc = 0;
    while ((sent < 150 || got < sent) && cyc < 2000) begin
      iv   = (sent < 150) && ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 9) < 7);
      p    = PW'($urandom);
      f    = (W-1)'($urandom);
      step(iv, p, f, ordy, acc, drn, d, e, ir, ov);
      exp_ir = !(inflight == 2 && !ordy);
      checks++;
      if (ir !== exp_ir) begin
        errors++;
        $display("FAIL rnd_in_ready cyc=%0d: got %b, want %b", cyc, ir, exp_ir);
      end
      if (drn) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra_beat: got data=%h, want none", d);
        end else begin
          exp_v = q.pop_front();
          if ({e, d} !== exp_v) begin
            errors++;
            $display("FAIL rnd_data beat %0d: got err=%b data=%h, want err=%b data=%h",
                     got, e, d, exp_v[W], exp_v[W-1:0]);
          end
        end
        got++;
        inflight--;
      end
      if (acc) begin
        q.push_back(model(int'(p), int'(f)));
        sent++;
        inflight++;
      end
      cyc++;
    end
    checks++;
    if (got != 150 || sent != 150) begin
      errors++;
      $display("FAIL rnd_count: got %0d of %0d sent, want 150 of 150", got, sent);
    end
  endtask

  task automatic test_reset_midflight();
    logic acc, drn, e, ir, ov;
    logic [W-1:0] d;
    logic [W:0] exp_v;
    int seen;
    step(1'b1, 4'd5, 7'h5B, 1'b0, acc, drn, d, e, ir, ov);
    step(1'b1, 4'd8, 7'h7F, 1'b0, acc, drn, d, e, ir, ov);
    step(1'b0, '0, '0, 1'b0, acc, drn, d, e, ir, ov);
    checks++;
    if (ov !== 1'b1 || ir !== 1'b0) begin
      errors++;
      $display("FAIL mid_full: got valid=%b in_ready=%b, want 1/0", ov, ir);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got valid=%b data=%h err=%b, want 0/00/0",
               out_valid, out_data, out_err);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_v = model(3, 'h70);
    step(1'b1, 4'd3, 7'h70, 1'b1, acc, drn, d, e, ir, ov);
    checks++;
    if (acc !== 1'b1) begin
      errors++;
      $display("FAIL mid_accept: got in_ready=%b, want 1", ir);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, '0, 1'b1, acc, drn, d, e, ir, ov);
      if (ov) begin
        seen++;
        checks++;
        if ({e, d} !== exp_v) begin
          errors++;
          $display("FAIL mid_new_beat: got err=%b data=%h, want err=%b data=%h",
                   e, d, exp_v[W], exp_v[W-1:0]);
        end
      end
    end
    checks++;
    if (seen != 1) begin
      errors++;
      $display("FAIL mid_beat_count: got %0d output beats, want 1", seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, want completion");
    $fatal(1, "timeout");
  end

endmodule
